sia_rxq: RTL

Receive-side companion of the SIA transmit queue. It deserialises an asynchronous, LSB-first frame arriving on rxd_i and stores each completed frame in a small first-word-fall-through FIFO for the host bus to read. Frame length and bit period are programmable and use the same encoding as the transmit queue. In the bench, the transmitter's txd_o is looped back into this block's rxd_i.

---
 rtl/sia_rxq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sia_rxq.sv
// ---------------------------------------------------------------------------
// sia_rxq -- SIA receive queue
//
// Deserialises an asynchronous, LSB-first frame from rxd_i and queues each
// completed frame in a small first-word-fall-through FIFO for the host.
// Frame length (bits_i) and bit period (baud_i) use the same encoding as
// the transmit queue.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous, active-high reset
//   rxd_i        asynchronous serial input, idles high
//   bits_i       frame length in bits incl. start/stop (sampled at start)
//   baud_i       bit period minus 1, in clocks (read at every reload)
//   re_i         pop the FIFO head
//   clr_i        clear the sticky overrun flag
//   dat_o        FIFO head, bit 0 = first bit received (start bit)
//   not_empty_o  FIFO holds at least one word
//   full_o       FIFO holds 2^DEPTH_BITS words
//   overrun_o    sticky: a frame was dropped because the FIFO was full
//   idle_o       receiver idle, no frame in progress
// ---------------------------------------------------------------------------
module sia_rxq #(
  parameter int SHIFT_REG_WIDTH = 12,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int DEPTH_BITS      = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rxd_i,
  input  logic [4:0]                 bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       re_i,
  input  logic                       clr_i,
  output logic [SHIFT_REG_WIDTH-1:0] dat_o,
  output logic                       not_empty_o,
  output logic                       full_o,
  output logic                       overrun_o,
  output logic                       idle_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int IDX_W = $clog2(SHIFT_REG_WIDTH + 1);
  localparam int PW    = DEPTH_BITS + 1;

  typedef enum logic [1:0] {IDLE, START, SHIFT, PUSH} state_t;

  // -------------------------------------------------------------------------
  // Input synchroniser and edge history (all idle high)
  // -------------------------------------------------------------------------
  logic rxd_m, rxd_s, rxd_p;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd_i;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver state
  // -------------------------------------------------------------------------
  state_t                       state, state_n;
  logic [BAUD_RATE_WIDTH-1:0]   cnt;
  logic [IDX_W-1:0]             idx, idx_inc, nbits, nbits_in;
  logic [SHIFT_REG_WIDTH-1:0]   sr;
  logic                         start_edge, cnt_zero, last_bit, short_frame;
  logic                         push;

  assign start_edge  = ~rxd_s & rxd_p;
  assign cnt_zero    = (cnt == '0);
  assign idx_inc     = idx + IDX_W'(1);
  assign last_bit    = (idx_inc >= nbits);
  // A frame of 0 or 1 bits consists of the start bit alone.
  assign short_frame = (nbits < IDX_W'(2));

  // Over-long frames are clamped to the shift register width.
  always_comb begin
    nbits_in = IDX_W'(bits_i);
    if (int'(bits_i) > SHIFT_REG_WIDTH)
      nbits_in = IDX_W'(SHIFT_REG_WIDTH);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start_edge) state_n = START;
      START: if (cnt_zero) begin
               if (rxd_s)            state_n = IDLE;   // false start
               else if (short_frame) state_n = PUSH;
               else                  state_n = SHIFT;
             end
      SHIFT: if (cnt_zero && last_bit) state_n = PUSH;
      PUSH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    push   = (state == PUSH);
    idle_o = (state == IDLE);
  end

  // Bit counter, index and shift register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt   <= '0;
      idx   <= '0;
      nbits <= '0;
      sr    <= '0;
    end else begin
      case (state)
        IDLE: if (start_edge) begin
          nbits <= nbits_in;
          cnt   <= baud_i >> 1;      // land the first sample mid start bit
          idx   <= '0;
          sr    <= '0;               // bits above the frame length stay 0
        end
        START: begin
          if (cnt_zero) begin
            sr[0] <= rxd_s;
            idx   <= IDX_W'(1);
            cnt   <= baud_i;
          end else begin
            cnt <= cnt - BAUD_RATE_WIDTH'(1);
          end
        end
        SHIFT: begin
          if (cnt_zero) begin
            sr  <= sr | (SHIFT_REG_WIDTH'(rxd_s) << idx);
            idx <= idx_inc;
            cnt <= baud_i;
          end else begin
            cnt <= cnt - BAUD_RATE_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0][SHIFT_REG_WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic          not_empty_q, full_q, overrun_q;
  logic          do_pop, do_push, drop;

  // A pop frees the slot in the same cycle, so push-while-full with a pop
  // is accepted and nothing is dropped.
  assign do_pop   = re_i & not_empty_q;
  assign do_push  = push & (~full_q | do_pop);
  assign drop     = push & full_q & ~do_pop;
  assign wr_ptr_n = wr_ptr + PW'(do_push);
  assign rd_ptr_n = rd_ptr + PW'(do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[DEPTH_BITS-1:0]] <= sr;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      not_empty_q <= 1'b0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      not_empty_q <= (wr_ptr_n != rd_ptr_n);
      full_q      <= (wr_ptr_n[DEPTH_BITS] != rd_ptr_n[DEPTH_BITS]) &&
                     (wr_ptr_n[DEPTH_BITS-1:0] == rd_ptr_n[DEPTH_BITS-1:0]);
      // A new overrun wins over a simultaneous clear.
      if (drop)       overrun_q <= 1'b1;
      else if (clr_i) overrun_q <= 1'b0;
    end
  end

  // Head is gated so stale storage never shows after reset or when empty.
  assign dat_o       = not_empty_q ? mem[rd_ptr[DEPTH_BITS-1:0]] : '0;
  assign not_empty_o = not_empty_q;
  assign full_o      = full_q;
  assign overrun_o   = overrun_q;

endmodule
